sd_req_arbiter: RTL and testbench

- Sequences the SD block-level handshake (sd_lba/sd_rd/sd_wr/sd_ack) of the MiST SPI user_io block and shares it between two core-side requesters, e.g. two virtual drives.
- Performs round-robin arbitration, holds the granted LBA stable, and synchronises sd_ack from the SPI clock domain.
- Routes the sector buffer write strobe and read data to and from the granted requester.
- Sits between user_io and the core's disk controllers.

---
 rtl/sd_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_sd_req_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_req_arbiter.sv
// Two-requester round-robin front end for the user_io SD block handshake.
// Optional REQ-state abort counter: define SD_ARB_TIMEOUT_EN.
module sd_req_arbiter #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [23:0] TIMEOUT     = 24'hFFFFFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [31:0] req_lba0,
    input  logic [31:0] req_lba1,
    input  logic [7:0]  req_buff_din0,
    input  logic [7:0]  req_buff_din1,
    output logic [1:0]  req_busy,
    output logic [1:0]  req_done,
    output logic [1:0]  req_err,
    output logic [1:0]  req_buff_wr,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_ack_conf,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic [SYNC_STAGES-1:0] conf_sync_q;
    logic                   ptr_q;
    logic [31:0]            lba_q;
    logic                   rd_q;
    logic                   wr_q;
    logic [1:0]             busy_q;
    logic [1:0]             done_q;
    logic                   ack_s;
    logic [1:0]             pend;
    logic                   sel;
    logic                   unused_conf;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ack_sync_q  <= '0;
            conf_sync_q <= '0;
        end else begin
            ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], sd_ack};
            conf_sync_q <= {conf_sync_q[SYNC_STAGES-2:0], sd_ack_conf};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        pend = req_rd | req_wr;
        sel  = (pend == 2'b11) ? ~ptr_q : pend[1];
    end

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] cnt_q;
    logic [1:0]  err_q;

    assign req_err     = err_q;
    assign unused_conf = conf_sync_q[SYNC_STAGES-1];
`else
    assign req_err     = 2'b00;
    assign unused_conf = conf_sync_q[SYNC_STAGES-1] ^ (^TIMEOUT);
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= '0;
            done_q  <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            done_q <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            err_q  <= '0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (|pend) begin
                        ptr_q   <= sel;
                        lba_q   <= sel ? req_lba1 : req_lba0;
                        rd_q    <= req_rd[sel];
                        wr_q    <= req_wr[sel] & ~req_rd[sel];
                        busy_q  <= sel ? 2'b10 : 2'b01;
                        state_q <= REQ;
`ifdef SD_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= XFER;
`ifdef SD_ARB_TIMEOUT_EN
                    end else if (cnt_q == TIMEOUT - 24'd1) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        busy_q  <= '0;
                        err_q   <= busy_q;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 24'd1;
`endif
                    end
                end
                XFER: begin
                    if (!ack_s) begin
                        done_q  <= busy_q;
                        busy_q  <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sd_lba      = lba_q;
    assign sd_rd       = rd_q;
    assign sd_wr       = wr_q;
    assign req_busy    = busy_q;
    assign req_done    = done_q;
    assign req_buff_wr = {2{sd_buff_wr}} & busy_q;

    always_comb begin
        sd_buff_din = 8'h00;
        if (busy_q[0])
            sd_buff_din = req_buff_din0;
        else if (busy_q[1])
            sd_buff_din = req_buff_din1;
    end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter: vector table plus corner sequences.
// Timeout section is compiled when SD_ARB_TIMEOUT_EN is defined.
module tb_sd_req_arbiter;

    localparam int SYNC = 2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [1:0]  req_rd, req_wr;
    logic [31:0] req_lba0, req_lba1;
    logic [7:0]  req_buff_din0, req_buff_din1;
    logic [1:0]  req_busy, req_done, req_err, req_buff_wr;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack, sd_ack_conf, sd_buff_wr;
    logic [7:0]  sd_buff_din;

    int n_chk = 0;
    int n_fail = 0;
    int busy_bad = 0;
    int done_seen = 0;
    int err_seen = 0;

    sd_req_arbiter #(.SYNC_STAGES(SYNC), .TIMEOUT(24'd100)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr),
        .req_lba0(req_lba0), .req_lba1(req_lba1),
        .req_buff_din0(req_buff_din0), .req_buff_din1(req_buff_din1),
        .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
        .req_buff_wr(req_buff_wr),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_ack_conf(sd_ack_conf),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (req_busy == 2'b11) busy_bad++;
        if (req_done != 2'b00) done_seen++;
        if (req_err != 2'b00) err_seen++;
    end

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] l0;
        logic [31:0] l1;
        int          gnt;
        logic        erd;
        logic        ewr;
        int          ack_len;
        int          npulse;
    } vec_t;

    vec_t vt[8];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (req_done == 2'b00 && k < 10) begin
            tick();
            k++;
        end
        chk(name, (k >= SYNC && k < 10), 1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] elba;
        logic [1:0]  oh;
        int cg, co, bad;
        logic [7:0] pb;
        elba = (v.gnt == 1) ? v.l1 : v.l0;
        oh   = (v.gnt == 1) ? 2'b10 : 2'b01;
        req_rd = v.rd;
        req_wr = v.wr;
        req_lba0 = v.l0;
        req_lba1 = v.l1;
        tick();
        chk("grant_busy", req_busy, oh);
        chk("grant_rd", sd_rd, v.erd);
        chk("grant_wr", sd_wr, v.ewr);
        chk("grant_lba", sd_lba, elba);
        req_lba0 = ~v.l0;
        req_lba1 = ~v.l1;
        repeat (9) tick();
        chk("lba_frozen", sd_lba, elba);
        chk("rd_hold_req", sd_rd, v.erd);
        sd_ack = 1'b1;
        tick();
        tick();
        chk("rdwr_before_sync", {sd_rd, sd_wr}, {v.erd, v.ewr});
        tick();
        chk("rdwr_clr_after_ack", {sd_rd, sd_wr}, 2'b00);
        cg = 0; co = 0; bad = 0;
        for (int p = 0; p < v.npulse; p++) begin
            pb = p[7:0];
            if (v.gnt == 1) begin
                req_buff_din1 = pb;
                req_buff_din0 = ~pb;
            end else begin
                req_buff_din0 = pb;
                req_buff_din1 = ~pb;
            end
            sd_buff_wr = 1'b1;
            #1;
            if (req_buff_wr[v.gnt]) cg++;
            if (req_buff_wr[1-v.gnt]) co++;
            if (sd_buff_din !== pb) bad++;
            tick();
            sd_buff_wr = 1'b0;
            tick();
        end
        chk("buff_wr_granted", cg, v.npulse);
        chk("buff_wr_other", co, 0);
        chk("buff_din_mux", bad, 0);
        repeat (v.ack_len) tick();
        sd_ack = 1'b0;
        wait_done("done_latency");
        chk("done_onehot", req_done, oh);
        chk("busy_at_done", req_busy, 2'b00);
        req_rd = 2'b00;
        req_wr = 2'b00;
        tick();
        chk("done_single", req_done, 2'b00);
        tick();
        chk("no_regrant", req_busy, 2'b00);
    endtask

    task automatic handshake();
        repeat (3) tick();
        sd_ack = 1'b1;
        repeat (6) tick();
        sd_ack = 1'b0;
    endtask

    task automatic wait_busy(output int g);
        int k = 0;
        while (req_busy == 2'b00 && k < 10) begin
            tick();
            k++;
        end
        chk("grant_within_bound", (k < 10), 1);
        g = req_busy[1] ? 1 : 0;
    endtask

    initial begin
        int g[3];
        int gg;
        int d0;
        vt[0] = '{2'b01, 2'b00, 32'h00001234, 32'h0000BEEF, 0, 1, 0, 600, 4};
        vt[1] = '{2'b10, 2'b00, 32'h11111111, 32'h22222222, 1, 1, 0, 20, 4};
        vt[2] = '{2'b00, 2'b10, 32'h33333333, 32'h0000ABCD, 1, 0, 1, 20, 512};
        vt[3] = '{2'b11, 2'b00, 32'h00000A0A, 32'h00000B0B, 0, 1, 0, 20, 4};
        vt[4] = '{2'b11, 2'b00, 32'h00000C0C, 32'h00000D0D, 1, 1, 0, 20, 4};
        vt[5] = '{2'b11, 2'b00, 32'h00000E0E, 32'h00000F0F, 0, 1, 0, 20, 4};
        vt[6] = '{2'b01, 2'b01, 32'hCAFEF00D, 32'h12345678, 0, 1, 0, 20, 4};
        vt[7] = '{2'b00, 2'b11, 32'h87654321, 32'hDEADBEEF, 1, 0, 1, 20, 4};

        reset = 1'b1;
        req_rd = 2'b00;
        req_wr = 2'b00;
        req_lba0 = 32'h0;
        req_lba1 = 32'h0;
        req_buff_din0 = 8'h00;
        req_buff_din1 = 8'h00;
        sd_ack = 1'b0;
        sd_ack_conf = 1'b0;
        sd_buff_wr = 1'b0;
        repeat (3) tick();
        chk("rst_ctrl", {req_busy, req_done, req_err, sd_rd, sd_wr}, 0);
        chk("rst_lba", sd_lba, 0);
        reset = 1'b0;
        sd_ack_conf = 1'b1;
        tick();
        chk("idle_ctrl", {req_busy, req_done, sd_rd, sd_wr}, 0);
        req_buff_din0 = 8'h77;
        sd_buff_wr = 1'b1;
        #1;
        chk("idle_buff_wr", req_buff_wr, 2'b00);
        chk("idle_buff_din", sd_buff_din, 8'h00);
        sd_buff_wr = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vt[i]);
        sd_ack_conf = 1'b0;

        req_rd = 2'b11;
        for (int i = 0; i < 3; i++) begin
            wait_busy(g[i]);
            handshake();
            wait_done("held_done");
        end
        req_rd = 2'b00;
        tick();
        tick();
        chk("held_order", {g[0][1:0], g[1][1:0], g[2][1:0]}, 6'b00_01_00);
        chk("busy_never_11", busy_bad, 0);

        req_rd = 2'b01;
        req_wr = 2'b01;
        for (int i = 0; i < 2; i++) begin
            wait_busy(gg);
            chk("both_gnt", gg, 0);
            chk("both_rdwr", {sd_rd, sd_wr}, 2'b10);
            handshake();
            wait_done("both_done");
        end
        req_rd = 2'b00;
        req_wr = 2'b00;
        tick();
        tick();

        req_lba0 = 32'h0000F00D;
        req_lba1 = 32'h00005555;
        req_rd = 2'b01;
        tick();
        chk("mid_busy", req_busy, 2'b01);
        sd_ack = 1'b1;
        repeat (4) tick();
        sd_buff_wr = 1'b1;
        req_buff_din0 = 8'h3C;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_ctrl", {req_busy, req_done, req_err, sd_rd, sd_wr}, 0);
        chk("rst_mid_lba", sd_lba, 0);
        chk("rst_mid_buff", {req_buff_wr, sd_buff_din}, 0);
        req_rd = 2'b00;
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        tick();
        reset = 1'b0;
        d0 = done_seen;
        repeat (5) tick();
        chk("rst_no_done", done_seen - d0, 0);
        req_rd = 2'b10;
        tick();
        chk("post_rst_gnt1", req_busy, 2'b10);
        chk("post_rst_lba", sd_lba, 32'h00005555);
        handshake();
        wait_done("post_rst_done");
        chk("post_rst_done1", req_done, 2'b10);
        req_rd = 2'b00;
        tick();
        tick();

`ifdef SD_ARB_TIMEOUT_EN
        begin
            int k = 0;
            req_rd = 2'b01;
            tick();
            chk("to_grant", req_busy, 2'b01);
            d0 = done_seen;
            while (req_err == 2'b00 && k < 200) begin
                tick();
                k++;
            end
            chk("to_cycles", k, 100);
            chk("to_err", req_err, 2'b01);
            chk("to_ctrl", {req_busy, req_done, sd_rd, sd_wr}, 0);
            req_rd = 2'b00;
            tick();
            chk("to_err_pulse", req_err, 2'b00);
            tick();
            chk("to_idle", req_busy, 2'b00);
            chk("to_no_done", done_seen - d0, 0);
        end
`else
        chk("err_tied_0", err_seen, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
